// File: rtl/freq_sweep_ctrl_pkg.sv
// Shared types and constants for the frequency-sweep controller.
// Holds the sweep state encoding and the period counts used by the FSM.
package freq_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    STORE,
    FINISH
  } sweep_state_t;

  localparam int unsigned MIN_SETTLE      = 1;
  localparam int unsigned MEASURE_PERIODS = 2;

endpackage

// File: rtl/sweep_result_ram.sv
// Simple dual-port results buffer: one write port, one registered read port.
// Read-during-write to the same address returns the previous contents.
module sweep_result_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Steps a sine generator through a list of FCWs, waits for the filter to settle,
// then records the peak-detector amplitude for each point in a results buffer.
module freq_sweep_ctrl
  import freq_sweep_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DATA_W-1:0]        fcw_start,
  input  logic [DATA_W-1:0]        fcw_step,
  input  logic [ADDR_W:0]          num_points,
  input  logic [3:0]               settle_periods,
  input  logic                     phase_wrap,
  input  logic signed [DATA_W-1:0] amplitude_in,
  output logic signed [DATA_W-1:0] fcw,
  output logic                     enable,
  output logic                     busy,
  output logic                     done,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  sweep_state_t      state;
  logic [DATA_W-1:0] step_q;
  logic [ADDR_W:0]   num_q;
  logic [3:0]        settle_q;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        wrap_cnt;

  logic [3:0] settle_target;
  logic       last_point;
  logic       we;

  // A programmed settle of zero still waits one period so the new FCW takes effect.
  assign settle_target = (settle_q < 4'(MIN_SETTLE)) ? 4'(MIN_SETTLE) : settle_q;
  assign last_point    = ({1'b0, idx} == (num_q - (ADDR_W+1)'(1)));
  assign we            = (state == STORE);

  // NOTE: enable/busy/done are registered alongside the state so they never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fcw      <= '0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_q   <= '0;
      num_q    <= '0;
      settle_q <= '0;
      idx      <= '0;
      wrap_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            step_q   <= fcw_step;
            num_q    <= num_points;
            settle_q <= settle_periods;
            fcw      <= $signed(fcw_start);
            idx      <= '0;
            wrap_cnt <= '0;
            if (num_points == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state  <= SETTLE;
              enable <= 1'b1;
              busy   <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (phase_wrap) begin
            if (wrap_cnt + 4'd1 >= settle_target) begin
              state    <= MEASURE;
              wrap_cnt <= '0;
            end else begin
              wrap_cnt <= wrap_cnt + 4'd1;
            end
          end
        end
        MEASURE: begin
          // First period primes the peak detector, the second is a full measured period.
          if (phase_wrap) begin
            if (wrap_cnt + 4'd1 >= 4'(MEASURE_PERIODS)) begin
              state    <= STORE;
              wrap_cnt <= '0;
            end else begin
              wrap_cnt <= wrap_cnt + 4'd1;
            end
          end
        end
        STORE: begin
          if (last_point) begin
            state  <= FINISH;
            done   <= 1'b1;
            enable <= 1'b0;
            busy   <= 1'b0;
          end else begin
            idx   <= idx + 1'b1;
            fcw   <= fcw + $signed(step_q);
            state <= SETTLE;
          end
        end
        FINISH: state <= IDLE;
        default: begin
          state  <= IDLE;
          enable <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  sweep_result_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .wr_addr(idx),
    .wr_data(amplitude_in),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Self-checking bench for freq_sweep_ctrl: the plant's amplitude is a function of FCW,
// so every stored point and the FCW sequence follow from the sweep configuration alone.
module tb_freq_sweep_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] fcw_start;
  logic [DW-1:0] fcw_step;
  logic [AW:0]   num_points;
  logic [3:0]    settle_periods;
  logic          phase_wrap;
  logic [DW-1:0] amplitude_in;
  logic [DW-1:0] fcw;
  logic          enable;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem_model [16];
  bit            mem_valid [16];
  logic [DW-1:0] cur_base;
  logic [DW-1:0] cur_gain;

  always #5 clk = ~clk;

  freq_sweep_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .fcw_start     (fcw_start),
    .fcw_step      (fcw_step),
    .num_points    (num_points),
    .settle_periods(settle_periods),
    .phase_wrap    (phase_wrap),
    .amplitude_in  (amplitude_in),
    .fcw           (fcw),
    .enable        (enable),
    .busy          (busy),
    .done          (done),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Peak amplitude the plant produces at a given FCW.
  function automatic logic [DW-1:0] plant(input logic [DW-1:0] f, input logic [DW-1:0] base,
                                          input logic [DW-1:0] gain);
    return base + f * gain;
  endfunction

  task automatic readback();
    for (int a = 0; a < 16; a++) begin
      if (mem_valid[a]) begin
        @(negedge clk);
        rd_addr = AW'(a);
        @(negedge clk);
        check($sformatf("rd_data[%0d]", a), rd_data, mem_model[a]);
      end
    end
  endtask

  task automatic sweep(input logic [DW-1:0] fs, input logic [DW-1:0] st, input int np,
                       input int s, input logic [DW-1:0] base, input logic [DW-1:0] gain,
                       input bit restart, input int abort_at);
    logic [DW-1:0] exp_fcw [$];
    logic [DW-1:0] seen_fcw [$];
    int  pulses, age, gap, cycles, s_eff, exp_pulses, stored;
    bit  ok_busy, seen_done, aborted, bad;

    s_eff      = (s < 1) ? 1 : s;
    exp_pulses = np * (s_eff + 2);
    for (int k = 0; k < np; k++) exp_fcw.push_back(fs + st * DW'(k));
    cur_base = base;
    cur_gain = gain;

    @(negedge clk);
    start          = 1'b1;
    fcw_start      = fs;
    fcw_step       = st;
    num_points     = (AW+1)'(np);
    settle_periods = 4'(s);
    phase_wrap     = 1'b1;  // lands in IDLE, must not count toward settling
    @(negedge clk);
    start          = 1'b0;
    phase_wrap     = 1'b0;
    fcw_start      = DW'($urandom);
    fcw_step       = DW'($urandom);
    num_points     = (AW+1)'($urandom);
    settle_periods = 4'($urandom);

    pulses = 0; age = 1; cycles = 0; gap = $urandom_range(0, 5);
    ok_busy = 1'b1; seen_done = 1'b0; aborted = 1'b0;
    while (cycles < 3000) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (!(busy === 1'b1 && enable === 1'b1)) ok_busy = 1'b0;
      if (seen_fcw.size() == 0 || seen_fcw[$] !== fcw) seen_fcw.push_back(fcw);
      amplitude_in = plant(fcw, cur_base, cur_gain);
      start = restart && ($urandom_range(0, 7) == 0);
      if (start) begin
        fcw_start      = DW'($urandom);
        fcw_step       = DW'($urandom);
        num_points     = (AW+1)'($urandom_range(1, 9));
        settle_periods = 4'($urandom);
      end
      if (gap == 0) begin
        phase_wrap = 1'b1; pulses++; age = 0; gap = $urandom_range(2, 7);
      end else begin
        phase_wrap = 1'b0; gap--; age++;
      end
      cycles++;
      if (abort_at >= 0 && phase_wrap && pulses == abort_at) begin
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;

    if (aborted) begin
      stored = abort_at / (s_eff + 2);
      for (int k = 0; k < stored && k < 16; k++) begin
        mem_model[k] = plant(exp_fcw[k], base, gain);
        mem_valid[k] = 1'b1;
      end
      @(negedge clk);
      phase_wrap = 1'b0;
      reset = 1'b1;
      #1;
      check("abort_fcw", fcw, 0);
      check("abort_busy", busy, 0);
      check("abort_enable", enable, 0);
      check("abort_done", done, 0);
      check("abort_rd_data", rd_data, 0);
      @(negedge clk);
      reset = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < 60; c++) begin
        phase_wrap = (c % 4 == 0);
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0 || enable !== 1'b0) bad = 1'b1;
      end
      phase_wrap = 1'b0;
      check("quiet_after_abort", bad, 0);
      readback();
      return;
    end

    phase_wrap = 1'b0;
    check("done_seen", seen_done, 1);
    check("busy_enable_during_sweep", ok_busy, 1);
    check("wrap_pulses_consumed", pulses, exp_pulses);
    if (np > 0) check("done_latency", age, 1);
    else        check("done_latency_empty", cycles, 0);
    check("busy_at_done", busy, 0);
    check("enable_at_done", enable, 0);
    check("fcw_point_count", seen_fcw.size(), np);
    for (int k = 0; k < np && k < seen_fcw.size(); k++)
      check($sformatf("fcw_point[%0d]", k), seen_fcw[k], exp_fcw[k]);

    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after", busy, 0);
    check("enable_after", enable, 0);
    check("fcw_held", fcw, (np > 0) ? exp_fcw[np-1] : fs);

    for (int k = 0; k < np && k < 16; k++) begin
      mem_model[k] = plant(exp_fcw[k], base, gain);
      mem_valid[k] = 1'b1;
    end
    readback();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; phase_wrap = 1'b0;
    fcw_start = '0; fcw_step = '0; num_points = '0; settle_periods = '0;
    amplitude_in = '0; rd_addr = '0;
    cur_base = '0; cur_gain = '0;
    for (int a = 0; a < 16; a++) begin
      mem_valid[a] = 1'b0;
      mem_model[a] = '0;
    end

    repeat (3) @(negedge clk);
    check("reset_fcw", fcw, 0);
    check("reset_busy", busy, 0);
    check("reset_enable", enable, 0);
    check("reset_done", done, 0);
    check("reset_rd_data", rd_data, 0);
    reset = 1'b0;

    sweep(16'd100, 16'd50, 4, 2, 16'd7, 16'd3, 1'b0, -1);
    sweep(16'd1, 16'd1, 3, 1, 16'd0, 16'd1000, 1'b0, -1);
    sweep(16'h7FF0, 16'h0020, 2, 0, 16'd11, 16'd1, 1'b0, -1);
    sweep(16'd5, 16'd5, 0, 1, 16'd0, 16'd1, 1'b0, -1);
    sweep(16'd300, 16'd7, 3, 1, 16'd2, 16'd9, 1'b1, -1);
    sweep(16'd40, 16'd4, 3, 2, 16'd9, 16'd5, 1'b0, 7);

    for (int r = 0; r < 6; r++)
      sweep(DW'($urandom), DW'($urandom), $urandom_range(0, 6), $urandom_range(0, 3),
            DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_sweep_ctrl.md
FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, results-buffer address width (max 2^ADDR_W points).
REQ-002 SHALL have parameter DATA_W, default 16, FCW and amplitude width.
REQ-003 SHALL have ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle sweep request.
- fcw_start  in  DATA_W  first frequency control word.
- fcw_step  in  DATA_W  FCW increment per point.
- num_points  in  ADDR_W+1  points to measure, 0..2^ADDR_W.
- settle_periods  in  4  sine periods discarded after each FCW change.
- phase_wrap  in  1  one-cycle pulse per completed generator period.
- amplitude_in  in  DATA_W signed  peak-detector output.
- fcw  out  DATA_W signed  FCW to sine generator.
- enable  out  1  generator/filter/peak-detector enable.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle sweep-complete pulse.
- rd_addr  in  ADDR_W  results read address.
- rd_data  out  DATA_W signed  stored amplitude at rd_addr.

Function
REQ-004 SHALL implement FSM states IDLE, SETTLE, MEASURE, STORE, FINISH.
REQ-005 IDLE: start=1 SHALL latch fcw_start, fcw_step, num_points, settle_periods; load fcw<=fcw_start, idx<=0, wrap count<=0; go SETTLE; if latched num_points==0 go FINISH instead.
REQ-006 start SHALL be ignored in every state except IDLE.
REQ-007 SETTLE: SHALL count phase_wrap pulses; on reaching max(settle_periods,1) go MEASURE, clearing count.
REQ-008 MEASURE: SHALL count phase_wrap pulses; on second pulse go STORE (first full period after settle updates the peak detector, second guarantees a complete measured period).
REQ-009 STORE (exactly one cycle): SHALL write amplitude_in to buffer[idx]; if idx==num_points-1 go FINISH, else idx<=idx+1, fcw<=fcw+fcw_step (modulo 2^DATA_W, wrap silently), go SETTLE.
REQ-010 FINISH (one cycle): done=1, then IDLE.
REQ-011 enable and busy SHALL be 1 in SETTLE, MEASURE, STORE; 0 in IDLE and FINISH.
REQ-012 fcw SHALL hold its value in IDLE/FINISH and change only on start-load or STORE.
REQ-013 phase_wrap coincident with a state transition SHALL be counted only by the state it arrives in the cycle of (registered state).
REQ-014 Read port SHALL have 1-cycle registered latency, operate in any state; read-during-write to the same address returns old data.
REQ-015 Buffer contents SHALL persist across sweeps until overwritten; unwritten locations undefined.

Reset
REQ-016 reset SHALL force state IDLE, fcw=0, enable=0, busy=0, done=0, idx=0, counters=0, rd_data=0; buffer contents not cleared.
REQ-017 reset asserted mid-sweep SHALL abort immediately; no done pulse; no further writes.

Structure
REQ-018 Shared package SHALL hold sweep_state_t enum and the minimum-settle constant (1) and measure-period constant (2).
REQ-019 Results buffer SHALL be a separate sub-module sweep_result_ram (simple dual-port, 1 write, 1 registered read, inferable BRAM).

Verification
REQ-020 start, fcw_start=100, fcw_step=50, num_points=4, settle=2, phase_wrap every 20 cycles -> fcw sequence 100,150,200,250; 4 writes; done once; enable low after.
REQ-021 num_points=0, start -> done pulse 1 cycle later, busy never 1, no buffer write.
REQ-022 fcw_start=16'h7FF0, fcw_step=16'h0020, num_points=2 -> second fcw = 16'h8010 (wrapped, signed negative).
REQ-023 reset pulsed during MEASURE of point 2 -> outputs at reset values next cycle, no done, buffer[1] unchanged.
REQ-024 start re-asserted while busy -> ignored; sweep completes with original config.
REQ-025 amplitude_in ramp per point (1000,2000,3000), then rd_addr=0,1,2 -> rd_data 1000,2000,3000 one cycle after each address.
